// File: rtl/reg_load_arbiter_pkg.sv
// Shared constants for the register-load arbiter: FSM encoding, default bus
// geometry and small index helpers used by the CPU datapath.
package reg_load_arbiter_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_NUM_REGS   = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_ACK   = 2'd2;
   localparam logic [1:0] ST_CLEAR = 2'd3;

   // Index width that stays legal for a single-entry range.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned oh_to_idx(input logic [31:0] oh);
      int unsigned idx;
      idx = 32'd0;
      for (int i = 0; i < 32; i++) begin
         if (oh[i]) begin
            idx = unsigned'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/reg_load_arbiter_if.sv
// Requester/register-bus bundle between the write requesters and the arbiter.
interface reg_load_arbiter_if
   import reg_load_arbiter_pkg::*;
#(
   parameter int DataWidth = DEF_DATA_WIDTH,
   parameter int NumReq    = DEF_NUM_REQ,
   parameter int NumRegs   = DEF_NUM_REGS
);
   localparam int AddrWidth = idx_width(NumRegs);

   logic [NumReq-1:0]           Req;
   logic [NumReq*AddrWidth-1:0] ReqAddr;
   logic [NumReq*DataWidth-1:0] ReqData;
   logic                        Clear;
   logic [NumRegs-1:0]          LDn;
   logic [DataWidth-1:0]        DOut;
   logic [NumReq-1:0]           Gnt;
   logic [NumReq-1:0]           Done;
   logic                        Busy;

   modport master (
      output Req, ReqAddr, ReqData, Clear,
      input  LDn, DOut, Gnt, Done, Busy
   );

   modport slave (
      input  Req, ReqAddr, ReqData, Clear,
      output LDn, DOut, Gnt, Done, Busy
   );

endinterface

// File: rtl/reg_load_arbiter_rr_picker.sv
// Combinational round-robin pick: lowest requester index at or above Ptr,
// wrapping past the top index back to zero.
module rr_picker
   import reg_load_arbiter_pkg::*;
#(
   parameter int NumReq   = DEF_NUM_REQ,
   parameter int PtrWidth = idx_width(NumReq)
) (
   input  logic [NumReq-1:0]   Req,
   input  logic [PtrWidth-1:0] Ptr,
   output logic [NumReq-1:0]   Winner,
   output logic                Valid
);

   logic [PtrWidth-1:0] idx_s;

   // Scan requesters in rotated order; the first hit wins.
   always_comb begin
      Winner = '0;
      Valid  = 1'b0;
      idx_s  = '0;
      for (int i = 0; i < NumReq; i++) begin
         idx_s = PtrWidth'((int'(Ptr) + i) % NumReq);
         if (!Valid && Req[idx_s]) begin
            Winner[idx_s] = 1'b1;
            Valid         = 1'b1;
         end else begin
            Valid = Valid;
         end
      end
   end

endmodule

// File: rtl/reg_load_arbiter.sv
// Arbitrates register writes from several requesters onto one shared load
// bus (active-low strobes plus data), with a walking clear of every register.
module reg_load_arbiter
   import reg_load_arbiter_pkg::*;
#(
   parameter int DataWidth = DEF_DATA_WIDTH,
   parameter int NumReq    = DEF_NUM_REQ,
   parameter int NumRegs   = DEF_NUM_REGS
) (
   input  logic               Clk,
   input  logic               Reset,
   reg_load_arbiter_if.slave  bus
);

   localparam int AddrWidth = idx_width(NumRegs);
   localparam int PtrWidth  = idx_width(NumReq);

   logic [1:0]           state_r,   state_n_s;
   logic [PtrWidth-1:0]  ptr_r,     ptr_n_s;
   logic [AddrWidth-1:0] cnt_r,     cnt_n_s;
   logic [PtrWidth-1:0]  win_idx_r, win_idx_n_s;
   logic [NumRegs-1:0]   ldn_r,     ldn_n_s;
   logic [DataWidth-1:0] dout_r,    dout_n_s;
   logic [NumReq-1:0]    gnt_r,     gnt_n_s;
   logic [NumReq-1:0]    done_r,    done_n_s;
   logic                 busy_r,    busy_n_s;

   logic [NumReq-1:0]    pick_oh_s;
   logic                 pick_valid_s;
   logic [PtrWidth-1:0]  pick_idx_s;
   logic [AddrWidth-1:0] addr_sel_s;
   logic [DataWidth-1:0] data_sel_s;

   rr_picker #(
      .NumReq   (NumReq),
      .PtrWidth (PtrWidth)
   ) u_picker (
      .Req    (bus.Req),
      .Ptr    (ptr_r),
      .Winner (pick_oh_s),
      .Valid  (pick_valid_s)
   );

   assign pick_idx_s = PtrWidth'(oh_to_idx(32'(pick_oh_s)));

   // One-hot mux of the winner's address and data slices.
   always_comb begin
      addr_sel_s = '0;
      data_sel_s = '0;
      for (int i = 0; i < NumReq; i++) begin
         addr_sel_s = addr_sel_s | ({AddrWidth{pick_oh_s[i]}} & bus.ReqAddr[i*AddrWidth +: AddrWidth]);
         data_sel_s = data_sel_s | ({DataWidth{pick_oh_s[i]}} & bus.ReqData[i*DataWidth +: DataWidth]);
      end
   end

   // Next-state and next-output logic; outputs are computed one cycle ahead
   // so the registered strobes line up with the state they belong to.
   always_comb begin
      state_n_s   = state_r;
      ptr_n_s     = ptr_r;
      cnt_n_s     = cnt_r;
      win_idx_n_s = win_idx_r;
      ldn_n_s     = '1;
      dout_n_s    = dout_r;
      gnt_n_s     = '0;
      done_n_s    = '0;
      case (state_r)
         ST_IDLE: begin
            if (bus.Clear) begin
               state_n_s = ST_CLEAR;
               cnt_n_s   = '0;
               ldn_n_s   = ~NumRegs'(1);
               dout_n_s  = '0;
            end else if (pick_valid_s) begin
               // Address and data are captured into the output registers here,
               // so later input changes cannot disturb the transfer.
               state_n_s   = ST_LOAD;
               win_idx_n_s = pick_idx_s;
               ldn_n_s     = ~(NumRegs'(1) << addr_sel_s);
               dout_n_s    = data_sel_s;
               gnt_n_s     = pick_oh_s;
            end else begin
               state_n_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            state_n_s = ST_ACK;
            gnt_n_s   = gnt_r;
            done_n_s  = gnt_r;
         end
         ST_ACK: begin
            state_n_s = ST_IDLE;
            if (win_idx_r == PtrWidth'(NumReq - 1)) begin
               ptr_n_s = '0;
            end else begin
               ptr_n_s = win_idx_r + PtrWidth'(1);
            end
         end
         ST_CLEAR: begin
            if (cnt_r == AddrWidth'(NumRegs - 1)) begin
               state_n_s = ST_IDLE;
            end else begin
               cnt_n_s  = cnt_r + AddrWidth'(1);
               ldn_n_s  = ~(NumRegs'(1) << cnt_n_s);
               dout_n_s = '0;
            end
         end
         default: begin
            state_n_s = ST_IDLE;
         end
      endcase
      busy_n_s = (state_n_s != ST_IDLE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_r   <= ST_IDLE;
         ptr_r     <= '0;
         cnt_r     <= '0;
         win_idx_r <= '0;
         ldn_r     <= '1;
         dout_r    <= '0;
         gnt_r     <= '0;
         done_r    <= '0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_n_s;
         ptr_r     <= ptr_n_s;
         cnt_r     <= cnt_n_s;
         win_idx_r <= win_idx_n_s;
         ldn_r     <= ldn_n_s;
         dout_r    <= dout_n_s;
         gnt_r     <= gnt_n_s;
         done_r    <= done_n_s;
         busy_r    <= busy_n_s;
      end
   end

   assign bus.LDn  = ldn_r;
   assign bus.DOut = dout_r;
   assign bus.Gnt  = gnt_r;
   assign bus.Done = done_r;
   assign bus.Busy = busy_r;

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Directed bench for reg_load_arbiter with a negedge-loading register file model.
module tb_reg_load_arbiter;

   localparam int DW = 8;
   localparam int NR = 4;
   localparam int NG = 8;
   localparam int AW = 3;

   logic Clk = 1'b0;
   logic Reset;
   int   checks = 0;
   int   errors = 0;

   logic [DW-1:0] regs   [NG] = '{default: '0};
   int            ld_cnt [NG] = '{default: 0};

   always #5 Clk = ~Clk;

   reg_load_arbiter_if #(.DataWidth(DW), .NumReq(NR), .NumRegs(NG)) bus ();

   reg_load_arbiter #(.DataWidth(DW), .NumReq(NR), .NumRegs(NG)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   // Registers on the shared bus load on the falling edge while their strobe is low.
   always @(negedge Clk) begin
      for (int i = 0; i < NG; i++) begin
         if (bus.LDn[i] === 1'b0) begin
            regs[i]   <= bus.DOut;
            ld_cnt[i] <= ld_cnt[i] + 1;
         end
      end
   end

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.ReqAddr[i*AW +: AW] = a;
      bus.ReqData[i*DW +: DW] = d;
   endtask

   task automatic test_reset;
      Reset = 1'b0;
      tick();
      checks++; if (bus.LDn !== 8'hFF) begin errors++; $display("FAIL reset_ldn got %h exp %h", bus.LDn, 8'hFF); end
      checks++; if (bus.DOut !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp %h", bus.DOut, 8'h00); end
      checks++; if (bus.Gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp %b", bus.Gnt, 4'b0000); end
      checks++; if (bus.Done !== 4'b0000) begin errors++; $display("FAIL reset_done got %b exp %b", bus.Done, 4'b0000); end
      checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp %b", bus.Busy, 1'b0); end
      Reset = 1'b1;
      tick();
      checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp %b", bus.Busy, 1'b0); end
   endtask

   task automatic test_single_write;
      set_req(0, 3'd3, 8'hA5);
      bus.Req = 4'b0001;
      tick();
      checks++; if (bus.LDn !== 8'hF7) begin errors++; $display("FAIL single_ldn got %h exp %h", bus.LDn, 8'hF7); end
      checks++; if (bus.DOut !== 8'hA5) begin errors++; $display("FAIL single_dout got %h exp %h", bus.DOut, 8'hA5); end
      checks++; if (bus.Gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt got %b exp %b", bus.Gnt, 4'b0001); end
      checks++; if (bus.Done !== 4'b0000) begin errors++; $display("FAIL single_early_done got %b exp %b", bus.Done, 4'b0000); end
      checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp %b", bus.Busy, 1'b1); end
      tick();
      checks++; if (bus.LDn !== 8'hFF) begin errors++; $display("FAIL single_ack_ldn got %h exp %h", bus.LDn, 8'hFF); end
      checks++; if (bus.Done !== 4'b0001) begin errors++; $display("FAIL single_done got %b exp %b", bus.Done, 4'b0001); end
      checks++; if (bus.Gnt !== 4'b0001) begin errors++; $display("FAIL single_ack_gnt got %b exp %b", bus.Gnt, 4'b0001); end
      bus.Req = 4'b0000;
      tick();
      checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %b exp %b", bus.Busy, 1'b0); end
      checks++; if (bus.Done !== 4'b0000) begin errors++; $display("FAIL single_idle_done got %b exp %b", bus.Done, 4'b0000); end
      checks++; if (bus.DOut !== 8'hA5) begin errors++; $display("FAIL single_dout_hold got %h exp %h", bus.DOut, 8'hA5); end
      checks++; if (regs[3] !== 8'hA5) begin errors++; $display("FAIL single_reg3 got %h exp %h", regs[3], 8'hA5); end
   endtask

   task automatic test_round_robin;
      int            order [5] = '{0, 1, 2, 3, 0};
      logic [NR-1:0] eg;
      logic [NG-1:0] el;
      Reset = 1'b0;
      tick();
      Reset = 1'b1;
      for (int i = 0; i < NR; i++) set_req(i, AW'(i), DW'(8'h10 + i));
      bus.Req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         eg = 4'b0001 << order[k];
         el = ~(8'b0000_0001 << order[k]);
         tick();
         checks++; if (bus.Gnt !== eg) begin errors++; $display("FAIL rr_gnt[%0d] got %b exp %b", k, bus.Gnt, eg); end
         checks++; if (bus.LDn !== el) begin errors++; $display("FAIL rr_ldn[%0d] got %h exp %h", k, bus.LDn, el); end
         checks++; if (bus.DOut !== DW'(8'h10 + order[k])) begin errors++; $display("FAIL rr_dout[%0d] got %h exp %h", k, bus.DOut, DW'(8'h10 + order[k])); end
         tick();
         checks++; if (bus.Done !== eg) begin errors++; $display("FAIL rr_done[%0d] got %b exp %b", k, bus.Done, eg); end
         checks++; if (bus.Gnt !== eg) begin errors++; $display("FAIL rr_ack_gnt[%0d] got %b exp %b", k, bus.Gnt, eg); end
         tick();
         checks++; if (bus.Gnt !== 4'b0000) begin errors++; $display("FAIL rr_idle_gnt[%0d] got %b exp %b", k, bus.Gnt, 4'b0000); end
         checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL rr_idle_busy[%0d] got %b exp %b", k, bus.Busy, 1'b0); end
      end
      bus.Req = 4'b0000;
      for (int i = 0; i < NR; i++) begin
         checks++; if (regs[i] !== DW'(8'h10 + i)) begin errors++; $display("FAIL rr_reg[%0d] got %h exp %h", i, regs[i], DW'(8'h10 + i)); end
      end
   endtask

   task automatic test_clear_vs_req;
      logic [NG-1:0] el;
      set_req(1, 3'd6, 8'h5C);
      bus.Req   = 4'b0010;
      bus.Clear = 1'b1;
      for (int c = 0; c < NG; c++) begin
         el = ~(8'b0000_0001 << c);
         tick();
         bus.Clear = 1'b0;
         checks++; if (bus.LDn !== el) begin errors++; $display("FAIL clr_ldn[%0d] got %h exp %h", c, bus.LDn, el); end
         checks++; if (bus.DOut !== 8'h00) begin errors++; $display("FAIL clr_dout[%0d] got %h exp %h", c, bus.DOut, 8'h00); end
         checks++; if (bus.Gnt !== 4'b0000) begin errors++; $display("FAIL clr_gnt[%0d] got %b exp %b", c, bus.Gnt, 4'b0000); end
         checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL clr_busy[%0d] got %b exp %b", c, bus.Busy, 1'b1); end
      end
      tick();
      checks++; if (bus.LDn !== 8'hFF) begin errors++; $display("FAIL clr_end_ldn got %h exp %h", bus.LDn, 8'hFF); end
      checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL clr_end_busy got %b exp %b", bus.Busy, 1'b0); end
      for (int i = 0; i < NG; i++) begin
         checks++; if (regs[i] !== 8'h00) begin errors++; $display("FAIL clr_reg[%0d] got %h exp %h", i, regs[i], 8'h00); end
      end
      tick();
      checks++; if (bus.Gnt !== 4'b0010) begin errors++; $display("FAIL clr_then_gnt got %b exp %b", bus.Gnt, 4'b0010); end
      checks++; if (bus.LDn !== 8'hBF) begin errors++; $display("FAIL clr_then_ldn got %h exp %h", bus.LDn, 8'hBF); end
      tick();
      checks++; if (bus.Done !== 4'b0010) begin errors++; $display("FAIL clr_then_done got %b exp %b", bus.Done, 4'b0010); end
      bus.Req = 4'b0000;
      tick();
   endtask

   task automatic test_input_change;
      set_req(0, 3'd5, 8'h11);
      bus.Req = 4'b0001;
      tick();
      checks++; if (bus.DOut !== 8'h11) begin errors++; $display("FAIL chg_dout got %h exp %h", bus.DOut, 8'h11); end
      checks++; if (bus.LDn !== 8'hDF) begin errors++; $display("FAIL chg_ldn got %h exp %h", bus.LDn, 8'hDF); end
      set_req(0, 3'd7, 8'h22);
      tick();
      checks++; if (bus.Done !== 4'b0001) begin errors++; $display("FAIL chg_done got %b exp %b", bus.Done, 4'b0001); end
      bus.Req = 4'b0000;
      tick();
      checks++; if (regs[5] !== 8'h11) begin errors++; $display("FAIL chg_reg5 got %h exp %h", regs[5], 8'h11); end
      checks++; if (regs[7] !== 8'h00) begin errors++; $display("FAIL chg_reg7 got %h exp %h", regs[7], 8'h00); end
      checks++; if (bus.DOut !== 8'h11) begin errors++; $display("FAIL chg_dout_hold got %h exp %h", bus.DOut, 8'h11); end
   endtask

   task automatic test_reset_mid_clear;
      int base [NG];
      for (int i = 0; i < NG; i++) base[i] = ld_cnt[i];
      bus.Clear = 1'b1;
      tick();
      bus.Clear = 1'b0;
      repeat (4) tick();
      checks++; if (bus.LDn !== 8'hEF) begin errors++; $display("FAIL rst_clr_cnt4_ldn got %h exp %h", bus.LDn, 8'hEF); end
      Reset = 1'b0;
      tick();
      checks++; if (bus.LDn !== 8'hFF) begin errors++; $display("FAIL rst_clr_ldn got %h exp %h", bus.LDn, 8'hFF); end
      checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL rst_clr_busy got %b exp %b", bus.Busy, 1'b0); end
      checks++; if (bus.Done !== 4'b0000) begin errors++; $display("FAIL rst_clr_done got %b exp %b", bus.Done, 4'b0000); end
      checks++; if (bus.DOut !== 8'h00) begin errors++; $display("FAIL rst_clr_dout got %h exp %h", bus.DOut, 8'h00); end
      Reset = 1'b1;
      repeat (2) tick();
      checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL rst_clr_after_busy got %b exp %b", bus.Busy, 1'b0); end
      checks++; if (ld_cnt[4] - base[4] !== 1) begin errors++; $display("FAIL rst_clr_reg4_loads got %0d exp %0d", ld_cnt[4] - base[4], 1); end
      for (int i = 5; i < NG; i++) begin
         checks++; if (ld_cnt[i] - base[i] !== 0) begin errors++; $display("FAIL rst_clr_reg%0d_loads got %0d exp %0d", i, ld_cnt[i] - base[i], 0); end
      end
   endtask

   task automatic test_wrap;
      set_req(2, 3'd1, 8'h33);
      bus.Req = 4'b0100;
      tick();
      checks++; if (bus.Gnt !== 4'b0100) begin errors++; $display("FAIL wrap_setup_gnt got %b exp %b", bus.Gnt, 4'b0100); end
      tick();
      bus.Req = 4'b0000;
      tick();
      set_req(3, 3'd2, 8'h44);
      set_req(0, 3'd4, 8'h55);
      bus.Req = 4'b1001;
      tick();
      checks++; if (bus.Gnt !== 4'b1000) begin errors++; $display("FAIL wrap_gnt3 got %b exp %b", bus.Gnt, 4'b1000); end
      checks++; if (bus.LDn !== 8'hFB) begin errors++; $display("FAIL wrap_ldn3 got %h exp %h", bus.LDn, 8'hFB); end
      checks++; if (bus.DOut !== 8'h44) begin errors++; $display("FAIL wrap_dout3 got %h exp %h", bus.DOut, 8'h44); end
      tick();
      checks++; if (bus.Done !== 4'b1000) begin errors++; $display("FAIL wrap_done3 got %b exp %b", bus.Done, 4'b1000); end
      bus.Req = 4'b0001;
      tick();
      checks++; if (bus.Gnt !== 4'b0000) begin errors++; $display("FAIL wrap_idle_gnt got %b exp %b", bus.Gnt, 4'b0000); end
      tick();
      checks++; if (bus.Gnt !== 4'b0001) begin errors++; $display("FAIL wrap_gnt0 got %b exp %b", bus.Gnt, 4'b0001); end
      checks++; if (bus.DOut !== 8'h55) begin errors++; $display("FAIL wrap_dout0 got %h exp %h", bus.DOut, 8'h55); end
      tick();
      checks++; if (bus.Done !== 4'b0001) begin errors++; $display("FAIL wrap_done0 got %b exp %b", bus.Done, 4'b0001); end
      bus.Req = 4'b0000;
      tick();
      checks++; if (regs[2] !== 8'h44) begin errors++; $display("FAIL wrap_reg2 got %h exp %h", regs[2], 8'h44); end
      checks++; if (regs[4] !== 8'h55) begin errors++; $display("FAIL wrap_reg4 got %h exp %h", regs[4], 8'h55); end
   endtask

   initial begin
      Reset       = 1'b0;
      bus.Req     = '0;
      bus.ReqAddr = '0;
      bus.ReqData = '0;
      bus.Clear   = 1'b0;
      test_reset();
      test_single_write();
      test_round_robin();
      test_clear_vs_req();
      test_input_change();
      test_reset_mid_clear();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_load_arbiter.md
REG_LOAD_ARBITER -- requirements
Module: reg_load_arbiter

Interface
REQ-001 Parameter DataWidth, 8, width of register data bus.
REQ-002 Parameter NumReq, 4, number of write requesters.
REQ-003 Parameter NumRegs, 8, number of registers on the shared bus; AddrWidth = clog2(NumRegs).
REQ-004 Port Clk  input  1  clock; all block state SHALL update on posedge Clk.
REQ-005 Port Reset  input  1  synchronous, active-low reset.
REQ-006 Port Req  input  NumReq  per-requester write request, active high, level.
REQ-007 Port ReqAddr  input  NumReq*AddrWidth  target register index per requester, slice i = requester i.
REQ-008 Port ReqData  input  NumReq*DataWidth  write data per requester, slice i = requester i.
REQ-009 Port Clear  input  1  request to zero all registers, active high, level.
REQ-010 Port LDn  output  NumRegs  per-register load strobe, active low, at most one bit low.
REQ-011 Port DOut  output  DataWidth  shared data bus to every register's data input.
REQ-012 Port Gnt  output  NumReq  one-hot grant, high while that requester's write is in flight.
REQ-013 Port Done  output  NumReq  one-cycle completion pulse to the winning requester.
REQ-014 Port Busy  output  1  high in every state other than IDLE.

Function
REQ-015 All outputs SHALL be registered; LDn and DOut SHALL be stable across the following negedge, where the registers load.
REQ-016 States SHALL be IDLE, LOAD, ACK, CLEAR.
REQ-017 IDLE: Clear high -> CLEAR with clear counter 0; else any Req bit high -> LOAD; else remain IDLE.
REQ-018 Clear SHALL take priority over Req when both are sampled high in IDLE.
REQ-019 On IDLE->LOAD the winner SHALL be chosen round-robin: lowest index at or above Ptr with Req high, wrapping from NumReq-1 to 0.
REQ-020 On IDLE->LOAD the winner's ReqAddr and ReqData SHALL be latched; later changes to those inputs SHALL have no effect on the transfer.
REQ-021 LOAD (exactly 1 cycle): LDn[latched addr]=0, DOut=latched data, Gnt[winner]=1; next state ACK.
REQ-022 ACK (exactly 1 cycle): LDn all 1, Done[winner]=1, Gnt[winner]=1; Ptr <= winner+1 mod NumReq; next state IDLE.
REQ-023 A requester SHALL deassert Req in the cycle it sees Done; Req still high in the following IDLE is a new request.
REQ-024 Latency: Req sampled at edge k -> LDn low during cycle k+1 -> Done high during cycle k+2 -> next arbitration at edge k+3.
REQ-025 CLEAR: each cycle LDn[cnt]=0, DOut=0, cnt increments; after cnt = NumRegs-1 -> IDLE; CLEAR lasts exactly NumRegs cycles.
REQ-026 CLEAR SHALL run to completion regardless of Clear deassertion; Req SHALL be ignored during CLEAR, and Ptr SHALL be unchanged.
REQ-027 In IDLE: LDn all 1, Gnt 0, Done 0, DOut holds its last value.
REQ-028 Requests arriving while Busy SHALL be held pending (level) and arbitrated at the next IDLE; none SHALL be lost or duplicated.

Reset
REQ-029 Reset=0 sampled at a posedge SHALL force state IDLE, LDn all 1, DOut 0, Gnt 0, Done 0, Busy 0, Ptr 0, clear counter 0, on that edge.
REQ-030 Reset mid-LOAD or mid-CLEAR SHALL abort without a Done pulse; reset SHALL override every other input.

Structure
REQ-031 The state encoding and the default NumReq, NumRegs and DataWidth constants SHALL live in a shared package used by the CPU datapath.
REQ-032 The round-robin pick SHALL be one sub-module, rr_picker (inputs Req and Ptr; outputs one-hot winner and a valid flag), combinational only.

Verification
REQ-033 Single write: Req=0001, ReqAddr0=3, ReqData0=0xA5 -> LDn=11110111 and DOut=0xA5 for one cycle, then Done=0001 for one cycle; register 3 reads 0xA5.
REQ-034 Round-robin: Req=1111 held for four grants from reset -> grant order 0,1,2,3, then 0 again; each grant lasts 2 cycles.
REQ-035 Clear vs Req: Clear=1 and Req=0010 in the same IDLE cycle -> 8 CLEAR cycles with LDn walking 11111110..01111111 and DOut=0, then requester 1 is granted.
REQ-036 Input change: ReqData0 changes from 0x11 to 0x22 during LOAD -> register receives 0x11.
REQ-037 Reset mid-CLEAR at count 4 -> on that edge LDn=0xFF, Busy=0, no Done; registers 5..7 are not loaded.
REQ-038 Wrap: Ptr=3 and Req=1001 -> requester 3 is granted first, Ptr becomes 0, then requester 0 is granted.
